mem_access: RTL and testbench

Memory-access stage of the five-stage core. It consumes the registered execute result (ALU value, destination register, write-enable) plus the memory-op fields from ex_mem and runs a request/acknowledge transaction on the data bus for LW/SW. While a transaction is pending it holds the upstream pipeline with a stall request. It delivers one registered result per instruction to mem_wb.

---
 rtl/mem_access.sv | 157 +++++++++++++++
 tb/tb_mem_access.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access stage: req/ack data bus with stall and timeout; optional MEM_ALIGN_CHECK_EN
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_w_reg_data,
    input  logic [4:0]  i_w_reg_addr,
    input  logic        i_wd,
    input  logic [1:0]  i_mem_op,
    input  logic [31:0] i_store_data,
    output logic        o_valid,
    output logic [31:0] o_w_reg_data,
    output logic [4:0]  o_w_reg_addr,
    output logic        o_wd,
    output logic        o_stall_req,
    output logic        o_bus_err,
    output logic        o_align_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] OP_LW   = 2'b01;
    localparam logic [1:0] OP_SW   = 2'b10;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [4:0]  addr_q, addr_d;
    logic        wd_q, wd_d;
    logic        bus_err_q, bus_err_d;
    logic        align_err_q, align_err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] baddr_q, baddr_d;
    logic [31:0] wdata_q, wdata_d;

    logic is_mem, misaligned, issue, timeout;

    assign is_mem = (i_mem_op == OP_LW) || (i_mem_op == OP_SW);
`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (i_w_reg_data[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign issue       = (state_q == IDLE) && i_valid && is_mem && !misaligned;
    assign timeout     = (state_q == BUSY) && !dbus_ack && (cnt_q == TO_LAST);
    assign o_stall_req = issue || ((state_q == BUSY) && !dbus_ack && !timeout);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        addr_d      = addr_q;
        wd_d        = wd_q;
        bus_err_d   = 1'b0;
        align_err_d = 1'b0;
        req_d       = req_q;
        we_d        = we_q;
        baddr_d     = baddr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (!is_mem) begin
                        valid_d = 1'b1;
                        data_d  = i_w_reg_data;
                        addr_d  = i_w_reg_addr;
                        wd_d    = i_wd;
                    end else if (misaligned) begin
                        align_err_d = 1'b1;
                    end else begin
                        // Word address only; with the align check on the low bits are already zero.
                        addr_d  = i_w_reg_addr;
                        wd_d    = i_wd && (i_mem_op != OP_SW);
                        baddr_d = {i_w_reg_data[31:2], 2'b00};
                        wdata_d = i_store_data;
                        we_d    = (i_mem_op == OP_SW);
                        req_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (dbus_ack) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = IDLE;
                    if (we_q) begin
                        data_d = baddr_q;
                        wd_d   = 1'b0;
                    end else begin
                        data_d = dbus_rdata;
                    end
                end else if (timeout) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            valid_q     <= 1'b0;
            data_q      <= 32'd0;
            addr_q      <= 5'd0;
            wd_q        <= 1'b0;
            bus_err_q   <= 1'b0;
            align_err_q <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            baddr_q     <= 32'd0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            bus_err_q   <= bus_err_d;
            align_err_q <= align_err_d;
            req_q       <= req_d;
            we_q        <= we_d;
            baddr_q     <= baddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_w_reg_data = data_q;
    assign o_w_reg_addr = addr_q;
    assign o_wd         = wd_q;
    assign o_bus_err    = bus_err_q;
    assign o_align_err  = align_err_q;
    assign dbus_req     = req_q;
    assign dbus_we      = we_q;
    assign dbus_addr    = baddr_q;
    assign dbus_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access (honours MEM_ALIGN_CHECK_EN)
module tb_mem_access;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_w_reg_data;
    logic [4:0]  i_w_reg_addr;
    logic        i_wd;
    logic [1:0]  i_mem_op;
    logic [31:0] i_store_data;
    logic        o_valid;
    logic [31:0] o_w_reg_data;
    logic [4:0]  o_w_reg_addr;
    logic        o_wd;
    logic        o_stall_req;
    logic        o_bus_err;
    logic        o_align_err;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_w_reg_data(i_w_reg_data),
        .i_w_reg_addr(i_w_reg_addr), .i_wd(i_wd), .i_mem_op(i_mem_op),
        .i_store_data(i_store_data), .o_valid(o_valid), .o_w_reg_data(o_w_reg_data),
        .o_w_reg_addr(o_w_reg_addr), .o_wd(o_wd), .o_stall_req(o_stall_req),
        .o_bus_err(o_bus_err), .o_align_err(o_align_err), .dbus_req(dbus_req),
        .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
    );

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  a;
        logic        wd;
        logic        ev;
        logic [31:0] ed;
        logic [4:0]  ea;
        logic        ewd;
    } vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  a;
        logic        wd;
        logic [31:0] st;
        logic [31:0] rd;
        int          k;
    } ins_t;

    typedef struct {
        int          kind;
        logic [31:0] d;
        logic [4:0]  a;
        logic        wd;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t expq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] a, input logic wd, input logic [31:0] st);
        i_valid = v; i_mem_op = op; i_w_reg_data = d;
        i_w_reg_addr = a; i_wd = wd; i_store_data = st;
    endtask

    function automatic bit is_mem(input logic [1:0] op);
        return (op == 2'b01) || (op == 2'b10);
    endfunction

    // Outcome of one instruction and how many cycles upstream must present it.
    task automatic predict(input ins_t c, output int len);
        exp_t e;
        e.kind = 0; e.d = c.d; e.a = c.a; e.wd = c.wd;
        len = 1;
        if (is_mem(c.op)) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (c.d[1:0] != 2'b00) begin
                e.kind = 2;
                expq.push_back(e);
                return;
            end
`endif
            if (c.k > TO) begin
                e.kind = 1;
                len = 1 + TO;
            end else begin
                len = 1 + c.k;
                if (c.op == 2'b01) e.d = c.rd;
                else begin
                    e.d  = {c.d[31:2], 2'b00};
                    e.wd = 1'b0;
                end
            end
        end
        expq.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        int   kind;
        if (o_valid || o_bus_err || o_align_err) begin
            kind = o_valid ? 0 : (o_bus_err ? 1 : 2);
            n_cmp++;
            if (expq.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got kind %0d expected no output", kind);
            end else begin
                e = expq.pop_front();
                chk("sb_kind", kind, e.kind);
                if (e.kind == 0) begin
                    chk("sb_data", o_w_reg_data, e.d);
                    chk("sb_addr", 32'(o_w_reg_addr), 32'(e.a));
                    chk("sb_wd", 32'(o_wd), 32'(e.wd));
                end
            end
        end
    endtask

    vec_t vt[5];
    ins_t cur;
    int   cur_len, present_cnt, busy_cnt;
    bit   have, prev_stall;

    initial begin
        vt[0] = '{1'b1, 2'b00, 32'h12345678, 5'd5,  1'b1, 1'b1, 32'h12345678, 5'd5,  1'b1};
        vt[1] = '{1'b1, 2'b11, 32'hA5A50001, 5'd31, 1'b1, 1'b1, 32'hA5A50001, 5'd31, 1'b1};
        vt[2] = '{1'b0, 2'b01, 32'h00000100, 5'd3,  1'b1, 1'b0, 32'h0,        5'd0,  1'b0};
        vt[3] = '{1'b1, 2'b00, 32'hFFFFFFFF, 5'd0,  1'b0, 1'b1, 32'hFFFFFFFF, 5'd0,  1'b0};
        vt[4] = '{1'b0, 2'b10, 32'h0,        5'd0,  1'b0, 1'b0, 32'h0,        5'd0,  1'b0};

        rst = 1'b1; dbus_ack = 1'b1; dbus_rdata = 32'h0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
        tick(); tick();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", o_w_reg_data, 0);
        chk("rst_addr", 32'(o_w_reg_addr), 0);
        chk("rst_wd", 32'(o_wd), 0);
        chk("rst_bus_err", 32'(o_bus_err), 0);
        chk("rst_align_err", 32'(o_align_err), 0);
        chk("rst_req", 32'(dbus_req), 0);
        chk("rst_we", 32'(dbus_we), 0);
        chk("rst_baddr", dbus_addr, 0);
        chk("rst_wdata", dbus_wdata, 0);
        chk("rst_stall", 32'(o_stall_req), 0);
        rst = 1'b0; dbus_ack = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            drive(vt[i].v, vt[i].op, vt[i].d, vt[i].a, vt[i].wd, 32'h0);
            #1;
            chk("vec_stall", 32'(o_stall_req), 0);
            tick();
            chk("vec_valid", 32'(o_valid), 32'(vt[i].ev));
            if (vt[i].ev) begin
                chk("vec_data", o_w_reg_data, vt[i].ed);
                chk("vec_addr", 32'(o_w_reg_addr), 32'(vt[i].ea));
                chk("vec_wd", 32'(o_wd), 32'(vt[i].ewd));
            end
        end
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();

        // LW with ack in the third bus cycle
        drive(1'b1, 2'b01, 32'h100, 5'd7, 1'b1, 32'h0);
        dbus_rdata = 32'hDEADBEEF; #1;
        chk("lw_accept_stall", 32'(o_stall_req), 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            dbus_ack = (i == 3); #1;
            chk("lw_req", 32'(dbus_req), 1);
            chk("lw_baddr", dbus_addr, 32'h100);
            chk("lw_we", 32'(dbus_we), 0);
            chk("lw_valid_busy", 32'(o_valid), 0);
            chk("lw_stall", 32'(o_stall_req), (i < 3) ? 1 : 0);
        end
        tick();
        dbus_ack = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
        chk("lw_done_valid", 32'(o_valid), 1);
        chk("lw_done_data", o_w_reg_data, 32'hDEADBEEF);
        chk("lw_done_addr", 32'(o_w_reg_addr), 7);
        chk("lw_done_wd", 32'(o_wd), 1);
        chk("lw_done_req", 32'(dbus_req), 0);
        tick();

        // SW with immediate ack, then an ALU op
        drive(1'b1, 2'b10, 32'h200, 5'd9, 1'b1, 32'hCAFEF00D); #1;
        chk("sw_accept_stall", 32'(o_stall_req), 1);
        tick();
        dbus_ack = 1'b1; #1;
        chk("sw_req", 32'(dbus_req), 1);
        chk("sw_we", 32'(dbus_we), 1);
        chk("sw_wdata", dbus_wdata, 32'hCAFEF00D);
        chk("sw_baddr", dbus_addr, 32'h200);
        chk("sw_ack_stall", 32'(o_stall_req), 0);
        tick();
        dbus_ack = 1'b0;
        chk("sw_done_valid", 32'(o_valid), 1);
        chk("sw_done_wd", 32'(o_wd), 0);
        chk("sw_done_data", o_w_reg_data, 32'h200);
        chk("sw_done_addr", 32'(o_w_reg_addr), 9);
        drive(1'b1, 2'b00, 32'h0BADC0DE, 5'd3, 1'b1, 32'h0); #1;
        chk("sw_next_stall", 32'(o_stall_req), 0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
        chk("sw_next_valid", 32'(o_valid), 1);
        chk("sw_next_data", o_w_reg_data, 32'h0BADC0DE);
        tick();

        // Timeout: no ack at all
        drive(1'b1, 2'b01, 32'h300, 5'd4, 1'b1, 32'h0);
        tick();
        for (int i = 0; i < TO; i++) begin
            chk("to_req", 32'(dbus_req), 1);
            chk("to_stall", 32'(o_stall_req), (i < TO - 1) ? 1 : 0);
            chk("to_no_err", 32'(o_bus_err), 0);
            tick();
        end
        chk("to_err", 32'(o_bus_err), 1);
        chk("to_req_off", 32'(dbus_req), 0);
        chk("to_valid", 32'(o_valid), 0);
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
        dbus_ack = 1'b1; #1;
        chk("to_idle_stall", 32'(o_stall_req), 0);
        tick();
        dbus_ack = 1'b0;
        chk("late_ack_err", 32'(o_bus_err), 0);
        chk("late_ack_valid", 32'(o_valid), 0);
        chk("late_ack_req", 32'(dbus_req), 0);
        tick();

        // Misaligned LW
        drive(1'b1, 2'b01, 32'h102, 5'd6, 1'b1, 32'h0);
        dbus_rdata = 32'h000055AA; #1;
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_stall", 32'(o_stall_req), 0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
        chk("mis_align_err", 32'(o_align_err), 1);
        chk("mis_req", 32'(dbus_req), 0);
        chk("mis_valid", 32'(o_valid), 0);
        tick();
        chk("mis_align_pulse", 32'(o_align_err), 0);
`else
        chk("mis_stall", 32'(o_stall_req), 1);
        tick();
        chk("mis_req", 32'(dbus_req), 1);
        chk("mis_baddr", dbus_addr, 32'h100);
        dbus_ack = 1'b1;
        tick();
        dbus_ack = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
        chk("mis_valid", 32'(o_valid), 1);
        chk("mis_data", o_w_reg_data, 32'h000055AA);
        chk("mis_align_err", 32'(o_align_err), 0);
`endif
        tick();

        // Reset in the middle of a transaction
        drive(1'b1, 2'b01, 32'h400, 5'd2, 1'b1, 32'h0);
        tick();
        chk("rstmid_req", 32'(dbus_req), 1);
        rst = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        chk("rstmid_req_off", 32'(dbus_req), 0);
        chk("rstmid_valid", 32'(o_valid), 0);
        dbus_ack = 1'b1;
        tick();
        dbus_ack = 1'b0;
        chk("rstmid_no_valid", 32'(o_valid), 0);
        tick();

        // Random instruction stream with a random-latency bus responder
        have = 1'b0; prev_stall = 1'b0; busy_cnt = 0; present_cnt = 0; cur_len = 0;
        cur = '{2'b00, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 1};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) tick();
            sb_check();
            if (dbus_req) begin
                busy_cnt++;
                chk("rnd_baddr", dbus_addr, {cur.d[31:2], 2'b00});
                chk("rnd_we", 32'(dbus_we), 32'(cur.op == 2'b10));
                chk("rnd_wdata", dbus_wdata, cur.st);
            end else begin
                busy_cnt = 0;
            end
            if (have && !prev_stall) begin
                chk("rnd_present_cycles", present_cnt, cur_len);
                have = 1'b0;
            end
            if (!have) begin
                if (cyc > 2900 || $urandom_range(3, 0) == 0) begin
                    drive(1'b0, 2'($urandom_range(3, 0)), $urandom, 5'($urandom), 1'($urandom), $urandom);
                end else begin
                    cur.op = 2'($urandom_range(3, 0));
                    cur.d  = $urandom;
                    if (is_mem(cur.op) && $urandom_range(3, 0) != 0) cur.d[1:0] = 2'b00;
                    cur.a  = 5'($urandom);
                    cur.wd = 1'($urandom);
                    cur.st = $urandom;
                    cur.rd = $urandom;
                    cur.k  = int'($urandom_range(6, 1));
                    predict(cur, cur_len);
                    drive(1'b1, cur.op, cur.d, cur.a, cur.wd, cur.st);
                    have = 1'b1;
                    present_cnt = 0;
                end
            end
            if (have) present_cnt++;
            dbus_rdata = have ? cur.rd : $urandom;
            dbus_ack = dbus_req ? (busy_cnt == cur.k) : ($urandom_range(7, 0) == 0);
            #1;
            prev_stall = o_stall_req;
        end
        chk("rnd_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
